// File: rtl/spy_delay_chain_probe.sv
// On-chip delay probe: a launch register drives a chain of inverting spy-path stages,
// and a launch/wait/capture FSM checks the selected tap and tallies pass/fail trials.
module spy_delay_chain_probe #(
  parameter int CHAIN_LEN = 50,
  parameter int TAP_W     = 6,
  parameter int WAIT_W    = 8,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [TAP_W-1:0]  tapSel,
  input  logic [WAIT_W-1:0] waitCycles,
  input  logic [CNT_W-1:0]  numTrials,
  input  logic              invertExpect,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  passCount,
  output logic [CNT_W-1:0]  failCount,
  output logic              lastSample
);

  // start is a request with no ready: it is taken only while idle, and any
  // pulse seen in LAUNCH/WAIT/CAPTURE/DONE is dropped, never queued.
  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t state;
  state_t state_n;

  logic              launch_q;
  logic [TAP_W-1:0]  tap_q;
  logic [WAIT_W-1:0] wait_cfg_q;
  logic [CNT_W-1:0]  trials_cfg_q;
  logic              inv_q;
  logic [WAIT_W-1:0] wait_q;
  logic [CNT_W-1:0]  trial_q;
  logic [CNT_W-1:0]  pass_q;
  logic [CNT_W-1:0]  fail_q;
  logic              sample_q;

  logic [TAP_W-1:0]  tap_clamped;
  logic              tap_value;
  logic              expected;
  logic              last_trial;

  (* keep = 1 *) logic [CHAIN_LEN:0] chain;

  assign chain[0] = launch_q;

  for (genvar i = 0; i < CHAIN_LEN; i++) begin : g_stage
    singlepath_1_spy_p5n u_stage (chain[i+1], chain[i], 1'b0, 1'b0, 1'b1, 1'b0);
  end

  // Selection is compared per tap so the index width need not match the chain depth.
  always_comb begin
    tap_value = 1'b0;
    for (int k = 0; k <= CHAIN_LEN; k++) begin
      if (tap_q == TAP_W'(k)) tap_value = chain[k];
    end
  end

  assign tap_clamped = (tapSel > TAP_W'(CHAIN_LEN)) ? TAP_W'(CHAIN_LEN) : tapSel;
  assign expected    = launch_q ^ tap_q[0] ^ inv_q;
  assign last_trial  = ((trial_q + CNT_W'(1)) == trials_cfg_q);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:    if (start) state_n = (numTrials == '0) ? S_DONE : S_LAUNCH;
      S_LAUNCH:  state_n = (wait_cfg_q != '0) ? S_WAIT : S_CAPTURE;
      S_WAIT:    if (wait_q == WAIT_W'(1)) state_n = S_CAPTURE;
      S_CAPTURE: state_n = last_trial ? S_DONE : S_LAUNCH;
      S_DONE:    state_n = S_IDLE;
      default:   state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      launch_q     <= 1'b0;
      tap_q        <= '0;
      wait_cfg_q   <= '0;
      trials_cfg_q <= '0;
      inv_q        <= 1'b0;
      wait_q       <= '0;
      trial_q      <= '0;
      pass_q       <= '0;
      fail_q       <= '0;
      sample_q     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            tap_q        <= tap_clamped;
            wait_cfg_q   <= waitCycles;
            trials_cfg_q <= numTrials;
            inv_q        <= invertExpect;
            trial_q      <= '0;
            pass_q       <= '0;
            fail_q       <= '0;
          end
        end
        S_LAUNCH: begin
          launch_q <= ~launch_q;
          wait_q   <= wait_cfg_q;
        end
        S_WAIT: begin
          wait_q <= wait_q - WAIT_W'(1);
        end
        S_CAPTURE: begin
          sample_q <= tap_value;
          trial_q  <= trial_q + CNT_W'(1);
          if (tap_value == expected) begin
            if (pass_q != '1) pass_q <= pass_q + CNT_W'(1);
          end else begin
            if (fail_q != '1) fail_q <= fail_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy       = (state == S_LAUNCH) || (state == S_WAIT) || (state == S_CAPTURE);
  assign done       = (state == S_DONE);
  assign passCount  = pass_q;
  assign failCount  = fail_q;
  assign lastSample = sample_q;

endmodule

// One spy-path cell: forced low/high overrides, otherwise inverts when inv_en
// is set and pass_en is clear; the probe ties it as a plain inverter.
module singlepath_1_spy_p5n (
  output logic y,
  input  logic a,
  input  logic force_lo,
  input  logic force_hi,
  input  logic inv_en,
  input  logic pass_en
);
  always_comb begin
    if (force_lo)      y = 1'b0;
    else if (force_hi) y = 1'b1;
    else               y = a ^ (inv_en & ~pass_en);
  end
endmodule

// File: tb/tb_spy_delay_chain_probe.sv
// Bench for spy_delay_chain_probe: directed runs plus randomized runs checked
// against a per-run model of cycle timing, counts and sampled polarity.
module tb_spy_delay_chain_probe;

  localparam int CHAIN_LEN = 50;
  localparam int TAP_W     = 6;
  localparam int WAIT_W    = 8;
  localparam int CNT_W     = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [TAP_W-1:0]  tapSel;
  logic [WAIT_W-1:0] waitCycles;
  logic [CNT_W-1:0]  numTrials;
  logic              invertExpect;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  passCount;
  logic [CNT_W-1:0]  failCount;
  logic              lastSample;

  int n_vec = 0;
  int n_err = 0;

  // Model state that persists across runs: launch level and last captured sample.
  int m_launch = 0;
  int m_last   = 0;

  spy_delay_chain_probe #(
    .CHAIN_LEN(CHAIN_LEN), .TAP_W(TAP_W), .WAIT_W(WAIT_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .tapSel(tapSel),
    .waitCycles(waitCycles), .numTrials(numTrials), .invertExpect(invertExpect),
    .busy(busy), .done(done), .passCount(passCount), .failCount(failCount),
    .lastSample(lastSample)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_reset_values();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", passCount, 0);
    check("rst_fail", failCount, 0);
    check("rst_last", lastSample, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_launch = 0;
    m_last   = 0;
    check_reset_values();
  endtask

  // One measurement run; optionally re-pulses start with altered inputs mid-run.
  task automatic run(input int tap, input int w, input int n, input int inv, input int disturb);
    int t, busy_end, exp_done, exp_pass, exp_fail;
    t        = (tap > CHAIN_LEN) ? CHAIN_LEN : tap;
    busy_end = n * (w + 2);
    exp_done = 1 + busy_end;
    exp_pass = (inv == 0) ? n : 0;
    exp_fail = (inv == 0) ? 0 : n;
    if (n > 0) begin
      m_launch = m_launch ^ (n % 2);
      m_last   = m_launch ^ (t % 2);
    end
    tapSel       = TAP_W'(tap);
    waitCycles   = WAIT_W'(w);
    numTrials    = CNT_W'(n);
    invertExpect = inv[0];
    start        = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 1; cyc <= exp_done; cyc++) begin
      check("busy", busy, (cyc <= busy_end) ? 1 : 0);
      check("done", done, (cyc == exp_done) ? 1 : 0);
      if (cyc == 1) begin
        check("clr_pass", passCount, 0);
        check("clr_fail", failCount, 0);
      end
      if (cyc == exp_done) begin
        check("pass", passCount, exp_pass);
        check("fail", failCount, exp_fail);
        check("last", lastSample, m_last);
      end
      if (disturb != 0 && cyc == 2) begin
        start        = 1'b1;
        tapSel       = TAP_W'(3);
        waitCycles   = WAIT_W'($urandom_range(0, 9));
        numTrials    = CNT_W'($urandom_range(1, 9));
        invertExpect = ~inv[0];
      end else begin
        start = 1'b0;
      end
      if (cyc < exp_done) begin
        @(posedge clk); #1;
      end
    end
    start = 1'b0;
    @(posedge clk); #1;
    check("post_done", done, 0);
    check("post_busy", busy, 0);
    check("hold_pass", passCount, exp_pass);
    check("hold_fail", failCount, exp_fail);
    check("hold_last", lastSample, m_last);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; tapSel = '0; waitCycles = '0;
    numTrials = '0; invertExpect = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_values();

    run(50, 3, 4, 0, 0);
    run(7, 0, 3, 0, 0);
    run(7, 0, 3, 1, 0);
    run(20, 2, 0, 0, 0);
    run(63, 1, 2, 0, 1);

    // Reset during WAIT of trial 2 (W=4: trial 2 waits in cycles 8..11).
    tapSel = 6'd11; waitCycles = 8'd4; numTrials = 16'd3; invertExpect = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 1; cyc < 9; cyc++) begin
      @(posedge clk); #1;
    end
    check("mid_busy", busy, 1);
    do_reset();
    @(posedge clk); #1;
    check_reset_values();
    run(5, 2, 2, 0, 0);

    for (int i = 0; i < 24; i++) begin
      run($urandom_range(0, 63), $urandom_range(0, 6), $urandom_range(0, 5),
          $urandom_range(0, 1), $urandom_range(0, 1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

endmodule
